// File: rtl/regfile_sb.sv
// regfile_sb: RISC-V integer register file with a write-pending scoreboard.
// Two combinational read ports with write-first forwarding, one synchronous
// write port, x0 hard-wired to zero, and a registered tap on register a0.
//
// Scoreboard handshake: issue_valid is a one-cycle strobe with no ready.
// When it is high at a rising edge, the register named by issue_rd becomes
// pending. A write on port 3 (WE3=1) retires the pending producer of AD3 at
// the same edge. If an issue and a writeback hit the same index at one edge,
// the issue wins and the bit stays set. Index 0 is never pending.
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int A0_INDEX   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] AD1,
  input  logic [ADDR_WIDTH-1:0] AD2,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  input  logic [ADDR_WIDTH-1:0] AD3,
  input  logic                  WE3,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  pending_any,
  output logic [DATA_WIDTH-1:0] a0
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A0_ADDR = ADDR_WIDTH'(A0_INDEX);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      pending_q;
  logic [DEPTH-1:0]      pending_d;
  logic                  pending_any_q;
  logic                  wr_en;
  logic                  fwd1;
  logic                  fwd2;

  // A write to x0 is dropped here, so entry 0 keeps its reset value of zero.
  assign wr_en = WE3 && (AD3 != '0);

  // Write-first match: a register being written this cycle is forwarded.
  assign fwd1 = WE3 && (AD3 == AD1);
  assign fwd2 = WE3 && (AD3 == AD2);

  // Register storage: cleared on reset, written on the edge when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[AD3] <= WD3;
    end
  end

  // Combinational read ports: x0 is zero, then forwarding, then storage.
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (AD1 != '0) begin
      RD1 = fwd1 ? WD3 : regs_q[AD1];
    end
    if (AD2 != '0) begin
      RD2 = fwd2 ? WD3 : regs_q[AD2];
    end
  end

  // Scoreboard next state: issue sets, writeback clears, issue wins a tie.
  always_comb begin
    pending_d = pending_q;
    for (int i = 1; i < DEPTH; i++) begin
      if (issue_valid && (issue_rd == ADDR_WIDTH'(i))) begin
        pending_d[i] = 1'b1;
      end else if (WE3 && (AD3 == ADDR_WIDTH'(i))) begin
        pending_d[i] = 1'b0;
      end
    end
    pending_d[0] = 1'b0;
  end

  // Scoreboard state and its summary bit. The summary is taken from the next
  // state so it is valid in the same cycle as the vector it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q     <= '0;
      pending_any_q <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      pending_any_q <= |pending_d;
    end
  end

  // Hazard flags: a register retiring this cycle is not busy, because its
  // value is already forwarded on the read port.
  assign busy1 = pending_q[AD1] && !fwd1 && (AD1 != '0);
  assign busy2 = pending_q[AD2] && !fwd2 && (AD2 != '0);

  assign pending_any = pending_any_q;

  // The debug tap shows stored contents only and is deliberately not forwarded.
  assign a0 = regs_q[A0_ADDR];

endmodule
